// File: rtl/scalar_wb_arbiter_if.sv
// Bundle between the scalar result sources, decode and the register-file write port.
// master = upstream/decode side, slave = writeback arbiter.
interface scalar_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int NREG = 2 ** ADDR_W;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_dst;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_dst;
    logic [NREG-1:0]   busy_mask;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output alu_valid, alu_dst, alu_data,
        input  alu_ready,
        output ld_valid, ld_dst, ld_data,
        input  ld_ready,
        output issue_en, issue_dst,
        input  busy_mask,
        input  wr_en, wr_dst, wr_data
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data,
        output alu_ready,
        input  ld_valid, ld_dst, ld_data,
        output ld_ready,
        input  issue_en, issue_dst,
        output busy_mask,
        output wr_en, wr_dst, wr_data
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: one skid entry per source, round-robin on conflict,
// registered register-file write port and a pending-write scoreboard.
module scalar_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic               i_clk,
    input logic               i_rst_n,
    scalar_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_t;

    rr_t               r_rr;
    rr_t               w_rr_next;

    logic              r_alu_full;
    logic [ADDR_W-1:0] r_alu_dst;
    logic [DATA_W-1:0] r_alu_data;
    logic              r_ld_full;
    logic [ADDR_W-1:0] r_ld_dst;
    logic [DATA_W-1:0] r_ld_data;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_dst;
    logic [DATA_W-1:0] r_wr_data;
    logic [NREG-1:0]   r_busy;

    logic              w_grant_alu;
    logic              w_grant_ld;
    logic              w_alu_take;
    logic              w_ld_take;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_busy_next;

    // Ready reflects buffer occupancy only, so a load can never coincide with a grant.
    assign w_alu_take = bus.alu_valid & ~r_alu_full;
    assign w_ld_take  = bus.ld_valid  & ~r_ld_full;

    // Grant selection; the pointer moves only when both buffers compete.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_ld  = 1'b0;
        w_rr_next   = r_rr;
        case ({r_alu_full, r_ld_full})
            2'b10: w_grant_alu = 1'b1;
            2'b01: w_grant_ld  = 1'b1;
            2'b11: begin
                if (r_rr == RR_ALU) begin
                    w_grant_alu = 1'b1;
                    w_rr_next   = RR_LD;
                end else begin
                    w_grant_ld  = 1'b1;
                    w_rr_next   = RR_ALU;
                end
            end
            default: begin
                w_grant_alu = 1'b0;
                w_grant_ld  = 1'b0;
            end
        endcase
    end

    // Scoreboard update: clear is applied before set so a fresh issue wins.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (r_wr_en) begin
            w_clr_mask = NREG'(1) << r_wr_dst;
        end else begin
            w_clr_mask = '0;
        end
        if (bus.issue_en) begin
            w_set_mask = NREG'(1) << bus.issue_dst;
        end else begin
            w_set_mask = '0;
        end
        w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr <= RR_ALU;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    // ALU skid entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_full <= 1'b0;
            r_alu_dst  <= '0;
            r_alu_data <= '0;
        end else if (w_grant_alu) begin
            r_alu_full <= 1'b0;
        end else if (w_alu_take) begin
            r_alu_full <= 1'b1;
            r_alu_dst  <= bus.alu_dst;
            r_alu_data <= bus.alu_data;
        end
    end

    // Load skid entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ld_full <= 1'b0;
            r_ld_dst  <= '0;
            r_ld_data <= '0;
        end else if (w_grant_ld) begin
            r_ld_full <= 1'b0;
        end else if (w_ld_take) begin
            r_ld_full <= 1'b1;
            r_ld_dst  <= bus.ld_dst;
            r_ld_data <= bus.ld_data;
        end
    end

    // Register-file write port; address and data hold when idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_dst  <= '0;
            r_wr_data <= '0;
        end else if (w_grant_alu) begin
            r_wr_en   <= 1'b1;
            r_wr_dst  <= r_alu_dst;
            r_wr_data <= r_alu_data;
        end else if (w_grant_ld) begin
            r_wr_en   <= 1'b1;
            r_wr_dst  <= r_ld_dst;
            r_wr_data <= r_ld_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Pending-write scoreboard.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.alu_ready = ~r_alu_full;
    assign bus.ld_ready  = ~r_ld_full;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_dst    = r_wr_dst;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy_mask = r_busy;
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed vector table, sustained-contention sequence,
// then randomized traffic against a queue-based reference model.
module tb_scalar_wb_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scalar_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    scalar_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ad;
        logic [15:0] adt;
        logic        lv;
        logic [3:0]  ldd;
        logic [15:0] ldt;
        logic        ie;
        logic [3:0]  id;
        logic        e_we;
        logic [3:0]  e_wd;
        logic [15:0] e_wdat;
        logic [15:0] e_busy;
        logic        e_ar;
        logic        e_lr;
    } vec_t;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
    } ent_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each source holds at most one queued result.
    ent_t        m_aq[$];
    ent_t        m_lq[$];
    bit          m_pref_ld;
    logic        m_wr_en;
    logic [3:0]  m_wr_dst;
    logic [15:0] m_wr_data;
    logic [15:0] m_busy;

    function automatic vec_t mkv(input logic r, av, input logic [3:0] ad, input logic [15:0] adt,
                                 input logic lv, input logic [3:0] ldd, input logic [15:0] ldt,
                                 input logic ie, input logic [3:0] id,
                                 input logic we, input logic [3:0] wd, input logic [15:0] wdat,
                                 input logic [15:0] bz, input logic ar, lr);
        vec_t v;
        v.rst = r; v.av = av; v.ad = ad; v.adt = adt; v.lv = lv; v.ldd = ldd; v.ldt = ldt;
        v.ie = ie; v.id = id; v.e_we = we; v.e_wd = wd; v.e_wdat = wdat; v.e_busy = bz;
        v.e_ar = ar; v.e_lr = lr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, av, input logic [3:0] ad, input logic [15:0] adt,
                         input logic lv, input logic [3:0] ldd, input logic [15:0] ldt,
                         input logic ie, input logic [3:0] id);
        rst_n = r;
        bus.alu_valid = av; bus.alu_dst = ad; bus.alu_data = adt;
        bus.ld_valid = lv;  bus.ld_dst = ldd; bus.ld_data = ldt;
        bus.issue_en = ie;  bus.issue_dst = id;
    endtask

    task automatic model_step();
        ent_t        w;
        ent_t        e;
        bit          have;
        bit          a_rdy;
        bit          l_rdy;
        logic [15:0] nb;
        if (!rst_n) begin
            m_aq.delete(); m_lq.delete();
            m_pref_ld = 1'b0;
            m_wr_en = 1'b0; m_wr_dst = 4'd0; m_wr_data = 16'd0; m_busy = 16'd0;
        end else begin
            a_rdy = (m_aq.size() == 0);
            l_rdy = (m_lq.size() == 0);
            nb = m_busy;
            if (m_wr_en) nb[m_wr_dst] = 1'b0;
            if (bus.issue_en) nb[bus.issue_dst] = 1'b1;
            m_busy = nb;
            have = 1'b1;
            if (m_aq.size() != 0 && m_lq.size() != 0) begin
                w = m_pref_ld ? m_lq.pop_front() : m_aq.pop_front();
                m_pref_ld = !m_pref_ld;
            end else if (m_aq.size() != 0) begin
                w = m_aq.pop_front();
            end else if (m_lq.size() != 0) begin
                w = m_lq.pop_front();
            end else begin
                have = 1'b0;
            end
            m_wr_en = have;
            if (have) begin
                m_wr_dst = w.dst;
                m_wr_data = w.data;
            end
            if (bus.alu_valid && a_rdy) begin
                e.dst = bus.alu_dst; e.data = bus.alu_data; m_aq.push_back(e);
            end
            if (bus.ld_valid && l_rdy) begin
                e.dst = bus.ld_dst; e.data = bus.ld_data; m_lq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " wr_en"},   32'(bus.wr_en),   32'(m_wr_en));
        chk({tag, " wr_dst"},  32'(bus.wr_dst),  32'(m_wr_dst));
        chk({tag, " wr_data"}, 32'(bus.wr_data), 32'(m_wr_data));
        chk({tag, " busy"},    32'(bus.busy_mask), 32'(m_busy));
        chk({tag, " alu_rdy"}, 32'(bus.alu_ready), 32'(m_aq.size() == 0));
        chk({tag, " ld_rdy"},  32'(bus.ld_ready),  32'(m_lq.size() == 0));
    endtask

    initial begin
        int          n_writes;
        bit          last_ld;
        bit          cur_ld;
        logic [15:0] exp_d;
        string       nm;

        // Reset with ALU valid, single write, two conflicts, scoreboard collisions, reset mid-flight.
        tbl.push_back(mkv(0,1,4'd7,16'h1111, 0,4'd0,16'h0, 0,4'd0, 0,4'd0,16'h0000,16'h0000,1,1));
        tbl.push_back(mkv(0,1,4'd7,16'h1111, 0,4'd0,16'h0, 0,4'd0, 0,4'd0,16'h0000,16'h0000,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 1,4'd3, 0,4'd0,16'h0000,16'h0008,1,1));
        tbl.push_back(mkv(1,1,4'd3,16'h1234, 0,4'd0,16'h0, 0,4'd0, 0,4'd0,16'h0000,16'h0008,0,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd3,16'h1234,16'h0008,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 0,4'd3,16'h1234,16'h0000,1,1));
        tbl.push_back(mkv(1,1,4'd1,16'hAAAA, 1,4'd2,16'h5555, 0,4'd0, 0,4'd3,16'h1234,16'h0000,0,0));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd1,16'hAAAA,16'h0000,1,0));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd2,16'h5555,16'h0000,1,1));
        tbl.push_back(mkv(1,1,4'd4,16'h0BBB, 1,4'd5,16'h0CCC, 0,4'd0, 0,4'd2,16'h5555,16'h0000,0,0));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd5,16'h0CCC,16'h0000,0,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd4,16'h0BBB,16'h0000,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 0,4'd4,16'h0BBB,16'h0000,1,1));
        tbl.push_back(mkv(1,1,4'd5,16'h0055, 0,4'd0,16'h0, 1,4'd5, 0,4'd4,16'h0BBB,16'h0020,0,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd5,16'h0055,16'h0020,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 1,4'd5, 0,4'd5,16'h0055,16'h0020,1,1));
        tbl.push_back(mkv(1,1,4'd5,16'h0056, 0,4'd0,16'h0, 0,4'd0, 0,4'd5,16'h0055,16'h0020,0,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 1,4'd5,16'h0056,16'h0020,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 1,4'd6, 0,4'd5,16'h0056,16'h0040,1,1));
        tbl.push_back(mkv(1,1,4'd7,16'h7777, 1,4'd8,16'h8888, 1,4'd5, 0,4'd5,16'h0056,16'h0060,0,0));
        tbl.push_back(mkv(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 0,4'd0,16'h0000,16'h0000,1,1));
        tbl.push_back(mkv(1,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0, 0,4'd0,16'h0000,16'h0000,1,1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].adt, tbl[i].lv, tbl[i].ldd, tbl[i].ldt,
                  tbl[i].ie, tbl[i].id);
            tick();
            nm = $sformatf("row%0d", i);
            chk({nm, " wr_en"},   32'(bus.wr_en),     32'(tbl[i].e_we));
            chk({nm, " wr_dst"},  32'(bus.wr_dst),    32'(tbl[i].e_wd));
            chk({nm, " wr_data"}, 32'(bus.wr_data),   32'(tbl[i].e_wdat));
            chk({nm, " busy"},    32'(bus.busy_mask), 32'(tbl[i].e_busy));
            chk({nm, " alu_rdy"}, 32'(bus.alu_ready), 32'(tbl[i].e_ar));
            chk({nm, " ld_rdy"},  32'(bus.ld_ready),  32'(tbl[i].e_lr));
        end

        // Sustained contention: both sources valid for 8 cycles, then drain.
        drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
        tick();
        n_writes = 0;
        last_ld  = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(1, 1, 4'(c), 16'hA000 + 16'(c), 1, 4'(c + 8), 16'h5000 + 16'(c), 0, 4'd0);
            else       drive(1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
            tick();
            check_model($sformatf("sus%0d", c));
            if (bus.wr_en) begin
                cur_ld = bus.wr_dst[3];
                exp_d  = cur_ld ? (16'h5000 + 16'(bus.wr_dst - 4'd8)) : (16'hA000 + 16'(bus.wr_dst));
                chk($sformatf("sus pair%0d", n_writes), 32'(bus.wr_data), 32'(exp_d));
                if (n_writes > 0) chk($sformatf("sus alt%0d", n_writes), 32'(cur_ld != last_ld), 32'd1);
                last_ld = cur_ld;
                n_writes++;
            end
        end
        chk("sus writes", 32'(n_writes), 32'd8);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 64) != 0, 1'($urandom), 4'($urandom), 16'($urandom),
                  1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
